// File: rtl/sysid_check_master.sv
// Avalon-MM read master: reads system ID (word 0) then build timestamp (word 1) and compares both against expected values.
// Latency: start to done = 3 cycles with a zero-wait slave; stalls and READ_LATENCY add cycles. Backpressure: waitrequest holds the request, bounded by TIMEOUT_CYCLES.
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1455550170,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ_ID, S_LAT_ID, S_REQ_TS, S_LAT_TS, S_FIN
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  LAT_LAST = 2'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        pass_q, pass_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        capture_id, capture_ts;
    logic        accept, stalled;

    assign avm_read    = (state_q == S_REQ_ID) || (state_q == S_REQ_TS);
    assign avm_address = (state_q == S_REQ_TS);
    assign done        = (state_q == S_FIN);
    assign accept      = avm_read && !avm_waitrequest;
    assign stalled     = avm_read && avm_waitrequest;

    assign busy     = busy_q;
    assign pass     = pass_q;
    assign id_ok    = id_ok_q;
    assign ts_ok    = ts_ok_q;
    assign timeout  = timeout_q;
    assign id_value = id_value_q;
    assign ts_value = ts_value_q;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        pass_d     = pass_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        lat_cnt_d  = lat_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        capture_id = 1'b0;
        capture_ts = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_REQ_ID;
                    busy_d     = 1'b1;
                    pass_d     = 1'b0;
                    id_ok_d    = 1'b0;
                    ts_ok_d    = 1'b0;
                    timeout_d  = 1'b0;
                    id_value_d = '0;
                    ts_value_d = '0;
                    tmo_cnt_d  = '0;
                end
            end
            S_REQ_ID: begin
                if (accept) begin
                    if (READ_LATENCY == 0) begin
                        capture_id = 1'b1;
                        state_d    = S_REQ_TS;
                        tmo_cnt_d  = '0;
                    end else begin
                        state_d   = S_LAT_ID;
                        lat_cnt_d = '0;
                    end
                end else if (stalled) begin
                    if (tmo_cnt_q == TMO_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = S_FIN;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 16'd1;
                    end
                end
            end
            S_LAT_ID: begin
                if (lat_cnt_q == LAT_LAST) begin
                    capture_id = 1'b1;
                    state_d    = S_REQ_TS;
                    tmo_cnt_d  = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            S_REQ_TS: begin
                if (accept) begin
                    if (READ_LATENCY == 0) begin
                        capture_ts = 1'b1;
                        state_d    = S_FIN;
                    end else begin
                        state_d   = S_LAT_TS;
                        lat_cnt_d = '0;
                    end
                end else if (stalled) begin
                    if (tmo_cnt_q == TMO_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = S_FIN;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 16'd1;
                    end
                end
            end
            S_LAT_TS: begin
                if (lat_cnt_q == LAT_LAST) begin
                    capture_ts = 1'b1;
                    state_d    = S_FIN;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // Compare flags load at the same edge as the captured word.
        if (capture_id) begin
            id_value_d = avm_readdata;
            id_ok_d    = (avm_readdata == EXPECTED_ID);
        end
        if (capture_ts) begin
            ts_value_d = avm_readdata;
            ts_ok_d    = (avm_readdata == EXPECTED_TS);
        end

        // pass uses next-state flags so it is valid during the done cycle.
        if ((state_d == S_FIN) && (state_q != S_FIN)) begin
            pass_d = id_ok_d & ts_ok_d & ~timeout_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            pass_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
            lat_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            pass_q     <= pass_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            lat_cnt_q  <= lat_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench for sysid_check_master: zero-latency instance with short timeout, plus a READ_LATENCY=2 instance.
module tb_sysid_check_master;

    localparam logic [31:0] TS_GOOD = 32'd1455550170;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // Instance 0: READ_LATENCY=0, TIMEOUT_CYCLES=8
    logic        start0 = 1'b0;
    logic        addr0, read0, wait0, busy0, done0, pass0, idok0, tsok0, tmo0;
    logic [31:0] rdata0, idv0, tsv0;
    logic [31:0] id_word = 32'h0;
    logic [31:0] ts_word = TS_GOOD;
    int          stall_len = 0;
    logic        stuck = 1'b0;
    int          stall_cnt = 0;
    int          rd_cyc0 = 0, addr1_cyc0 = 0, viol0 = 0;
    logic        prev_stall = 1'b0, prev_addr = 1'b0;

    assign wait0  = stuck || (stall_cnt < stall_len);
    assign rdata0 = addr0 ? ts_word : id_word;

    always @(posedge clock) begin
        stall_cnt <= (read0 && wait0) ? stall_cnt + 1 : 0;
        if (read0) rd_cyc0 <= rd_cyc0 + 1;
        if (read0 && addr0) addr1_cyc0 <= addr1_cyc0 + 1;
        if (prev_stall && reset_n && (!read0 || addr0 != prev_addr)) viol0 <= viol0 + 1;
        prev_stall <= read0 && wait0;
        prev_addr  <= addr0;
    end

    sysid_check_master #(.READ_LATENCY(0), .TIMEOUT_CYCLES(8)) u0 (
        .clock(clock), .reset_n(reset_n), .start(start0),
        .avm_address(addr0), .avm_read(read0), .avm_waitrequest(wait0),
        .avm_readdata(rdata0), .busy(busy0), .done(done0), .pass(pass0),
        .id_ok(idok0), .ts_ok(tsok0), .timeout(tmo0),
        .id_value(idv0), .ts_value(tsv0)
    );

    // Instance 2: READ_LATENCY=2, data valid only for the capture edge, garbage otherwise
    logic        start2 = 1'b0;
    logic        addr2, read2, busy2, done2, pass2, idok2, tsok2, tmo2;
    logic [31:0] rdata2, idv2, tsv2;
    logic        p0 = 1'b0, p1 = 1'b0, a0 = 1'b0, a1 = 1'b0;
    logic        wait2 = 1'b0;

    always @(posedge clock) begin
        p0 <= read2 && !wait2;
        a0 <= addr2;
        p1 <= p0;
        a1 <= a0;
    end
    assign rdata2 = p1 ? (a1 ? TS_GOOD : 32'h0) : 32'hDEAD_BEEF;

    sysid_check_master #(.READ_LATENCY(2)) u2 (
        .clock(clock), .reset_n(reset_n), .start(start2),
        .avm_address(addr2), .avm_read(read2), .avm_waitrequest(wait2),
        .avm_readdata(rdata2), .busy(busy2), .done(done2), .pass(pass2),
        .id_ok(idok2), .ts_ok(tsok2), .timeout(tmo2),
        .id_value(idv2), .ts_value(tsv2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until the selected instance pulses done; n = edges from the start edge, -1 if none within budget.
    task automatic wait_done(input int which, output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if ((which == 0 && done0) || (which == 2 && done2)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pulse_start0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    initial begin
        int n, snap_rd, snap_a1, snap_v, extra;
        tick();
        tick();
        check("reset_outputs0", {busy0, done0, pass0, idok0, tsok0, tmo0, read0, addr0}, 0);
        check("reset_values0", idv0 | tsv0, 0);
        check("reset_outputs2", {busy2, done2, pass2, read2}, 0);
        reset_n = 1'b1;
        tick();

        // 1: zero-wait, good data
        start0 = 1'b1;
        wait_done(0, n);
        start0 = 1'b0;
        check("t1_done_latency", n, 3);
        check("t1_flags", {pass0, idok0, tsok0, tmo0}, 4'b1110);
        check("t1_values", tsv0, TS_GOOD);
        tick();
        check("t1_after_done", {done0, busy0, pass0}, 3'b001);

        // 2: wrong timestamp
        ts_word = 32'h1234_5678;
        start0 = 1'b1;
        wait_done(0, n);
        start0 = 1'b0;
        check("t2_flags", {pass0, idok0, tsok0, tmo0}, 4'b0100);
        check("t2_ts_value", tsv0, 32'h1234_5678);
        ts_word = TS_GOOD;
        tick();

        // 3: 4 stall cycles per read
        stall_len = 4;
        snap_v = viol0;
        start0 = 1'b1;
        wait_done(0, n);
        start0 = 1'b0;
        check("t3_done_latency", n, 11);
        check("t3_pass", pass0, 1);
        tick();
        check("t3_stable_req", viol0 - snap_v, 0);
        stall_len = 0;

        // 4: stuck waitrequest, timeout after 8 stalled cycles
        stuck = 1'b1;
        snap_rd = rd_cyc0;
        snap_a1 = addr1_cyc0;
        start0 = 1'b1;
        wait_done(0, n);
        start0 = 1'b0;
        check("t4_done_latency", n, 9);
        check("t4_flags", {pass0, idok0, tsok0, tmo0}, 4'b0001);
        check("t4_id_value", idv0, 0);
        tick();
        check("t4_read_cycles", rd_cyc0 - snap_rd, 8);
        check("t4_no_addr1", addr1_cyc0 - snap_a1, 0);
        check("t4_read_low", read0, 0);
        stuck = 1'b0;

        // 5: READ_LATENCY=2, garbage at +1
        start2 = 1'b1;
        wait_done(2, n);
        start2 = 1'b0;
        check("t5_done_latency", n, 7);
        check("t5_flags", {pass2, idok2, tsok2, tmo2}, 4'b1110);
        check("t5_id_value", idv2, 0);
        check("t5_ts_value", tsv2, TS_GOOD);
        tick();

        // 6a: reset during REQ_TS
        pulse_start0();
        tick();
        check("t6_in_req_ts", {read0, addr0}, 2'b11);
        reset_n = 1'b0;
        tick();
        check("t6_reset_ctrl", {read0, busy0, done0}, 0);
        check("t6_reset_results", {pass0, idok0, tsok0, tmo0} | idv0 | tsv0, 0);
        reset_n = 1'b1;
        tick();

        // 6b: repeated start while busy
        pulse_start0();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done(0, n);
        check("t6_rep_latency", n, 1);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            extra = extra | done0 | read0 | busy0;
        end
        check("t6_no_second_seq", extra, 0);

        // Start in the done cycle is ignored; start one cycle later is accepted
        pulse_start0();
        wait_done(0, n);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("start_at_done_ignored", {busy0, read0}, 2'b00);
        pulse_start0();
        check("start_after_done", {busy0, read0, addr0}, 3'b110);
        wait_done(0, n);
        check("start_after_done_pass", pass0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
